// File: rtl/vram_arbiter.sv
// vram_arbiter: arbitrates a single-port synchronous VRAM (1-cycle read latency) between an
// absolute-priority video fetch port and NUM_CH round-robin requestor channels.
// Commands are registered onto mem_* one cycle after arbitration; read data returns
// three cycles after the request cycle with a one-hot channel tag (or vid_valid_o).
// Optional per-byte write mask: define VRAM_ARB_WRMASK_EN.
module vram_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n_i,
  input  logic                       vid_sel_i,
  input  logic [ADDR_W-1:0]          vid_addr_i,
  output logic [DATA_W-1:0]          vid_data_o,
  output logic                       vid_valid_o,
  input  logic [NUM_CH-1:0]          ch_req_i,
  input  logic [NUM_CH-1:0]          ch_wr_i,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
`ifdef VRAM_ARB_WRMASK_EN
  input  logic [NUM_CH*DATA_W/8-1:0] ch_wrmask_i,
  output logic [DATA_W/8-1:0]        mem_wrmask_o,
`endif
  output logic [NUM_CH-1:0]          ch_ack_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [NUM_CH-1:0]          rd_valid_o,
  output logic                       mem_sel_o,
  output logic                       mem_wr_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_data_o,
  input  logic [DATA_W-1:0]          mem_data_i
);

  localparam int unsigned PtrW = $clog2(NUM_CH);

  // Read-return tag carried alongside each issued command.
  typedef struct packed {
    logic              vid;
    logic [NUM_CH-1:0] ch;
    logic              rd;
  } tag_t;

  // (base + off) mod NUM_CH for off < NUM_CH.
  function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    return sum[PtrW-1:0];
  endfunction

  logic [ADDR_W-1:0] ch_addr [NUM_CH];
  logic [DATA_W-1:0] ch_data [NUM_CH];
  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_addr[k] = ch_addr_i[k*ADDR_W +: ADDR_W];
    assign ch_data[k] = ch_data_i[k*DATA_W +: DATA_W];
  end

  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              sel_q, sel_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  tag_t              tag1_q, tag1_d;
  tag_t              tag2_q;
  logic [NUM_CH-1:0] rd_valid_q, rd_valid_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;

  logic [NUM_CH-1:0] elig;
  logic              grant_vld;
  logic [PtrW-1:0]   grant_idx;

  // Round-robin search from the pointer; last cycle's grantee is skipped while its req drains.
  always_comb begin
    elig      = ch_req_i & ~ack_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_vld && elig[wrap_add(ptr_q, i)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_add(ptr_q, i);
      end
    end
  end

  // Command next-state: video wins outright, else the round-robin winner, else idle.
  always_comb begin
    ptr_d  = ptr_q;
    ack_d  = '0;
    sel_d  = 1'b0;
    wr_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    tag1_d = '0;
    if (vid_sel_i) begin
      sel_d      = 1'b1;
      addr_d     = vid_addr_i;
      tag1_d.vid = 1'b1;
      tag1_d.rd  = 1'b1;
    end else if (grant_vld) begin
      sel_d            = 1'b1;
      wr_d             = ch_wr_i[grant_idx];
      addr_d           = ch_addr[grant_idx];
      ack_d[grant_idx] = 1'b1;
      ptr_d            = wrap_add(grant_idx, 1);
      if (ch_wr_i[grant_idx]) begin
        data_d = ch_data[grant_idx];
      end else begin
        tag1_d.ch = ack_d;
        tag1_d.rd = 1'b1;
      end
    end
  end

  // Read-return stage: mem_data_i is valid while tag2_q describes the read that produced it.
  always_comb begin
    rd_valid_d  = tag2_q.rd ? tag2_q.ch : '0;
    vid_valid_d = tag2_q.rd & tag2_q.vid;
    rd_data_d   = (|rd_valid_d) ? mem_data_i : rd_data_q;
    vid_data_d  = vid_valid_d ? mem_data_i : vid_data_q;
  end

  // State and output registers; reset discards any in-flight read.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q       <= '0;
      ack_q       <= '0;
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      rd_valid_q  <= '0;
      vid_valid_q <= 1'b0;
      rd_data_q   <= '0;
      vid_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      rd_valid_q  <= rd_valid_d;
      vid_valid_q <= vid_valid_d;
      rd_data_q   <= rd_data_d;
      vid_data_q  <= vid_data_d;
    end
  end

`ifdef VRAM_ARB_WRMASK_EN
  localparam int unsigned BeW = DATA_W / 8;

  logic [BeW-1:0] ch_mask [NUM_CH];
  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack_mask
    assign ch_mask[k] = ch_wrmask_i[k*BeW +: BeW];
  end

  logic [BeW-1:0] mask_q, mask_d;

  // Byte mask: granted mask on writes, all-ones on any read, zero when idle.
  always_comb begin
    mask_d = '0;
    if (vid_sel_i) begin
      mask_d = '1;
    end else if (grant_vld) begin
      mask_d = ch_wr_i[grant_idx] ? ch_mask[grant_idx] : '1;
    end
  end

  // Mask register issued alongside the command.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mem_wrmask_o = mask_q;
`endif

  assign ch_ack_o    = ack_q;
  assign mem_sel_o   = sel_q;
  assign mem_wr_o    = wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign vid_valid_o = vid_valid_q;
  assign vid_data_o  = vid_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized + directed bench for vram_arbiter with a VRAM model and a
// cycle-indexed reference model of the arbitration rules. Honors VRAM_ARB_WRMASK_EN.
module tb_vram_arbiter;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BE_W   = DATA_W / 8;
  localparam int MAXC   = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset_n_i;
  logic                     vid_sel_i;
  logic [ADDR_W-1:0]        vid_addr_i;
  logic [DATA_W-1:0]        vid_data_o;
  logic                     vid_valid_o;
  logic [NUM_CH-1:0]        ch_req_i;
  logic [NUM_CH-1:0]        ch_wr_i;
  logic [NUM_CH*ADDR_W-1:0] ch_addr_i;
  logic [NUM_CH*DATA_W-1:0] ch_data_i;
  logic [NUM_CH-1:0]        ch_ack_o;
  logic [DATA_W-1:0]        rd_data_o;
  logic [NUM_CH-1:0]        rd_valid_o;
  logic                     mem_sel_o;
  logic                     mem_wr_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic [DATA_W-1:0]        mem_data_o;
  logic [DATA_W-1:0]        mem_data_i;
  logic [BE_W-1:0]          wmask;
`ifdef VRAM_ARB_WRMASK_EN
  logic [NUM_CH*BE_W-1:0]   ch_wrmask_i;
  logic [BE_W-1:0]          mem_wrmask_o;
  assign wmask = mem_wrmask_o;
`else
  assign wmask = '1;
`endif

  vram_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset_n_i   (reset_n_i),
    .vid_sel_i   (vid_sel_i),
    .vid_addr_i  (vid_addr_i),
    .vid_data_o  (vid_data_o),
    .vid_valid_o (vid_valid_o),
    .ch_req_i    (ch_req_i),
    .ch_wr_i     (ch_wr_i),
    .ch_addr_i   (ch_addr_i),
    .ch_data_i   (ch_data_i),
`ifdef VRAM_ARB_WRMASK_EN
    .ch_wrmask_i (ch_wrmask_i),
    .mem_wrmask_o(mem_wrmask_o),
`endif
    .ch_ack_o    (ch_ack_o),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .mem_sel_o   (mem_sel_o),
    .mem_wr_o    (mem_wr_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i)
  );

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BE_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Synchronous single-port VRAM, read data one cycle after select.
  logic [DATA_W-1:0] vram [0:65535];
  initial for (int i = 0; i < 65536; i++) vram[i] <= DATA_W'(i * 7 + 3);
  always @(posedge clk) begin
    if (mem_sel_o) begin
      if (mem_wr_o) vram[mem_addr_o] <= merge(vram[mem_addr_o], mem_data_o, wmask);
      else          mem_data_i <= vram[mem_addr_o];
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] shadow [0:65535];
  int                m_ptr, m_last;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic              e_sel [MAXC];
  logic              e_wr  [MAXC];
  logic [ADDR_W-1:0] e_addr[MAXC];
  logic [DATA_W-1:0] e_data[MAXC];
  logic [NUM_CH-1:0] e_ack [MAXC];
  logic [NUM_CH-1:0] e_rdv [MAXC];
  logic [DATA_W-1:0] e_rdd [MAXC];
  logic              e_vv  [MAXC];
  logic [DATA_W-1:0] e_vd  [MAXC];
  logic [BE_W-1:0]   e_mask[MAXC];

  // Requestor state.
  logic [NUM_CH-1:0] r_req, r_wr, r_hold;
  logic [ADDR_W-1:0] r_addr[NUM_CH];
  logic [DATA_W-1:0] r_data[NUM_CH];
  logic [BE_W-1:0]   r_mask[NUM_CH];
  int unsigned       gen_pct, hold_pct;

  int cyc, n_checks, n_fail;
  int cnt_a, cnt_b;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_expect(input int from);
    for (int i = from; i < MAXC; i++) begin
      e_sel[i] = 1'b0;  e_wr[i] = 1'b0;  e_addr[i] = '0; e_data[i] = '0; e_ack[i] = '0;
      e_rdv[i] = '0;    e_rdd[i] = '0;   e_vv[i] = 1'b0; e_vd[i] = '0;   e_mask[i] = '0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_addr = '0; m_data = '0;
    r_req = '0; r_wr = '0; r_hold = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      r_addr[k] = '0; r_data[k] = '0; r_mask[k] = '1;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NUM_CH; k++) begin
      ch_req_i[k] = r_req[k];
      ch_wr_i[k]  = r_wr[k];
      ch_addr_i[k*ADDR_W +: ADDR_W] = r_addr[k];
      ch_data_i[k*DATA_W +: DATA_W] = r_data[k];
`ifdef VRAM_ARB_WRMASK_EN
      ch_wrmask_i[k*BE_W +: BE_W] = r_mask[k];
`endif
    end
  endtask

  task automatic check_outputs(input int c);
    check_eq("mem_sel", 64'(mem_sel_o), 64'(e_sel[c]));
    check_eq("mem_wr", 64'(mem_wr_o), 64'(e_wr[c]));
    check_eq("mem_addr", 64'(mem_addr_o), 64'(e_addr[c]));
    if (e_wr[c]) check_eq("mem_data", 64'(mem_data_o), 64'(e_data[c]));
    check_eq("ch_ack", 64'(ch_ack_o), 64'(e_ack[c]));
    check_eq("rd_valid", 64'(rd_valid_o), 64'(e_rdv[c]));
    if (e_rdv[c] != '0) check_eq("rd_data", 64'(rd_data_o), 64'(e_rdd[c]));
    check_eq("vid_valid", 64'(vid_valid_o), 64'(e_vv[c]));
    if (e_vv[c]) check_eq("vid_data", 64'(vid_data_o), 64'(e_vd[c]));
`ifdef VRAM_ARB_WRMASK_EN
    check_eq("mem_wrmask", 64'(mem_wrmask_o), 64'(e_mask[c]));
`endif
    check_eq("ack_onehot0", 64'($countones(ch_ack_o) <= 1), 64'(1));
    check_eq("valid_excl", 64'((|rd_valid_o) && vid_valid_o), 64'(0));
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_mem_sel", 64'(mem_sel_o), 64'(0));
    check_eq("rst_mem_wr", 64'(mem_wr_o), 64'(0));
    check_eq("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    check_eq("rst_mem_data", 64'(mem_data_o), 64'(0));
    check_eq("rst_ch_ack", 64'(ch_ack_o), 64'(0));
    check_eq("rst_rd_valid", 64'(rd_valid_o), 64'(0));
    check_eq("rst_rd_data", 64'(rd_data_o), 64'(0));
    check_eq("rst_vid_valid", 64'(vid_valid_o), 64'(0));
    check_eq("rst_vid_data", 64'(vid_data_o), 64'(0));
`ifdef VRAM_ARB_WRMASK_EN
    check_eq("rst_mem_wrmask", 64'(mem_wrmask_o), 64'(0));
`endif
  endtask

  // Requestors drop req when acked (optionally one cycle late) and may issue new requests.
  task automatic update_requesters(input int c);
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_hold[k]) begin
        r_hold[k] = 1'b0;
        r_req[k]  = 1'b0;
      end else if (r_req[k] && e_ack[c][k]) begin
        if ($urandom_range(99) < hold_pct) r_hold[k] = 1'b1;
        else                               r_req[k]  = 1'b0;
      end
      if (!r_req[k] && gen_pct > 0 && $urandom_range(99) < gen_pct) begin
        r_req[k]  = 1'b1;
        r_wr[k]   = 1'($urandom_range(0, 1));
        r_addr[k] = ADDR_W'($urandom_range(0, 31));
        r_data[k] = DATA_W'($urandom);
`ifdef VRAM_ARB_WRMASK_EN
        r_mask[k] = BE_W'($urandom);
`endif
      end
    end
  endtask

  // Reference: decision on cycle-c inputs, command visible at c+1, read data at c+3.
  task automatic model(input int c);
    int g, k;
    g = -1;
    e_sel[c+1] = 1'b0; e_wr[c+1] = 1'b0; e_ack[c+1] = '0; e_mask[c+1] = '0;
    if (vid_sel_i) begin
      e_sel[c+1]  = 1'b1;
      e_mask[c+1] = '1;
      m_addr      = vid_addr_i;
      e_vv[c+3]   = 1'b1;
      e_vd[c+3]   = shadow[vid_addr_i];
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        k = (m_ptr + i) % NUM_CH;
        if (g < 0 && r_req[k] && k != m_last) g = k;
      end
      if (g >= 0) begin
        e_sel[c+1]    = 1'b1;
        e_ack[c+1][g] = 1'b1;
        m_addr        = r_addr[g];
        m_ptr         = (g + 1) % NUM_CH;
        if (r_wr[g]) begin
          e_wr[c+1]   = 1'b1;
          e_mask[c+1] = r_mask[g];
          m_data      = r_data[g];
          shadow[r_addr[g]] = merge(shadow[r_addr[g]], r_data[g], r_mask[g]);
        end else begin
          e_mask[c+1]   = '1;
          e_rdv[c+3][g] = 1'b1;
          e_rdd[c+3]    = shadow[r_addr[g]];
        end
      end
    end
    m_last      = g;
    e_addr[c+1] = m_addr;
    e_data[c+1] = m_data;
  endtask

  task automatic step(input logic vid, input logic [ADDR_W-1:0] vaddr);
    @(negedge clk);
    cyc++;
    check_outputs(cyc);
    update_requesters(cyc);
    vid_sel_i  = vid;
    vid_addr_i = vaddr;
    drive();
    model(cyc);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    gen_pct = 0; hold_pct = 0;
    for (int i = 0; i < 65536; i++) shadow[i] = DATA_W'(i * 7 + 3);
    clear_expect(0);
    model_reset();
    vid_sel_i = 1'b0; vid_addr_i = '0;
    ch_req_i = '0; ch_wr_i = '0; ch_addr_i = '0; ch_data_i = '0;
`ifdef VRAM_ARB_WRMASK_EN
    ch_wrmask_i = '0;
`endif
    drive();
    reset_n_i = 1'b1;
    #2 reset_n_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset_n_i = 1'b1;

    // Round-robin: all four write at once, expect acks 0..3 one per cycle.
    for (int k = 0; k < NUM_CH; k++) begin
      r_req[k] = 1'b1; r_wr[k] = 1'b1; r_addr[k] = ADDR_W'(k); r_data[k] = DATA_W'(16'hA000 + k);
    end
    step(1'b0, '0);
    for (int i = 0; i < NUM_CH; i++) begin
      step(1'b0, '0);
      check_eq("rr_ack", 64'(ch_ack_o), 64'(1 << i));
      check_eq("rr_addr", 64'(mem_addr_o), 64'(i));
    end
    repeat (4) step(1'b0, '0);

    // Single read: write 0xBEEF to 0x1234 via ch0, then read it on ch2.
    r_req[0] = 1'b1; r_wr[0] = 1'b1; r_addr[0] = 16'h1234; r_data[0] = 16'hBEEF;
    repeat (4) step(1'b0, '0);
    r_req[2] = 1'b1; r_wr[2] = 1'b0; r_addr[2] = 16'h1234;
    step(1'b0, '0);
    step(1'b0, '0);
    check_eq("sr_ack", 64'(ch_ack_o), 64'(4'b0100));
    check_eq("sr_addr", 64'(mem_addr_o), 64'(16'h1234));
    step(1'b0, '0);
    step(1'b0, '0);
    check_eq("sr_rd_valid", 64'(rd_valid_o), 64'(4'b0100));
    check_eq("sr_rd_data", 64'(rd_data_o), 64'(16'hBEEF));
    repeat (3) step(1'b0, '0);

    // Video priority: 5 video cycles while ch1 waits.
    r_req[1] = 1'b1; r_wr[1] = 1'b0; r_addr[1] = 16'h0005;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 12; i++) begin
      step(i < 5, ADDR_W'(40 + i));
      cnt_a += int'(vid_valid_o);
      cnt_b += int'(ch_ack_o[1]);
      if (i == 6) check_eq("vp_ack_after_vid", 64'(ch_ack_o), 64'(4'b0010));
    end
    check_eq("vp_vid_pulses", 64'(cnt_a), 64'(5));
    check_eq("vp_ch1_acks", 64'(cnt_b), 64'(1));

    // Double-grant guard: ch0 holds req one cycle past its ack.
    hold_pct = 100;
    r_req[0] = 1'b1; r_wr[0] = 1'b1; r_addr[0] = 16'h0007; r_data[0] = 16'h1357;
    r_mask[0] = '1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0);
      cnt_a += int'(ch_ack_o[0]);
      cnt_b += int'(mem_sel_o);
      if (i == 2) check_eq("guard_sel_low", 64'(mem_sel_o), 64'(0));
    end
    check_eq("guard_acks", 64'(cnt_a), 64'(1));
    check_eq("guard_sel_cycles", 64'(cnt_b), 64'(1));

    // Random traffic, then a stretch of continuous video (starvation).
    gen_pct = 40; hold_pct = 30;
    for (int i = 0; i < 1200; i++) step($urandom_range(99) < 20, ADDR_W'($urandom_range(0, 31)));
    for (int i = 0; i < 20; i++) step(1'b1, ADDR_W'($urandom_range(0, 31)));
    gen_pct = 0;
    repeat (12) step(1'b0, '0);

`ifdef VRAM_ARB_WRMASK_EN
    // Masked write of 0xAABB, upper byte only, then read it back.
    hold_pct = 0;
    r_req[1] = 1'b1; r_wr[1] = 1'b1; r_addr[1] = 16'h0100; r_data[1] = 16'hAABB;
    r_mask[1] = 2'b10;
    step(1'b0, '0);
    step(1'b0, '0);
    check_eq("wm_mask", 64'(mem_wrmask_o), 64'(2'b10));
    check_eq("wm_wr", 64'(mem_wr_o), 64'(1));
    r_req[1] = 1'b1; r_wr[1] = 1'b0;
    repeat (2) step(1'b0, '0);
    check_eq("wm_rd_mask", 64'(mem_wrmask_o), 64'(2'b11));
    repeat (4) step(1'b0, '0);
`endif

    // Reset while a read is in flight: outputs clear at once, no valid afterwards.
    hold_pct = 0;
    r_req[3] = 1'b1; r_wr[3] = 1'b0; r_addr[3] = 16'h0009;
    step(1'b0, '0);
    step(1'b0, '0);
    check_eq("mr_issued", 64'(mem_sel_o), 64'(1));
    #2 reset_n_i = 1'b0;
    #1 check_reset_outputs();
    clear_expect(cyc + 1);
    model_reset();
    vid_sel_i = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    repeat (6) step(1'b0, '0);

    gen_pct = 50; hold_pct = 20;
    for (int i = 0; i < 200; i++) step($urandom_range(99) < 15, ADDR_W'($urandom_range(0, 31)));
    gen_pct = 0;
    repeat (8) step(1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
